// File: rtl/reg_bank_arbiter.sv
// Purpose : shares one bank of 2**ADDR_W x DATA_W registers between N_REQ write
//           requesters. A round-robin arbiter grants one requester at a time, and
//           a 3-state FSM (IDLE/GRANT/WRITE) latches the winner's address and data,
//           writes the bank and returns a one-cycle ack.
// Latency : req sampled at edge k -> grant after k; bank write and ack after k+1;
//           IDLE after k+2. At most one write every 3 cycles.
// Backpres: a requester holds req/addr/data until it samples ack; losers wait.
//           The read port is independent: rd_data <= bank[rd_addr] on every edge.
// Config  : `define REG_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
//           wins, no rotating pointer). The default build is round-robin.
// Ports   : clk, rst (async, active-high); req[N_REQ], req_addr[N_REQ*ADDR_W],
//           req_data[N_REQ*DATA_W] in; grant[N_REQ], ack, busy out;
//           rd_addr[ADDR_W] in; rd_data[DATA_W] out (registered).
module reg_bank_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic [N_REQ-1:0]         grant,
   output logic                     ack,
   output logic                     busy,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_data;
   logic [DATA_W-1:0]   bank [DEPTH];
   logic [PTR_W-1:0]    win;
   logic                win_vld;

`ifdef REG_ARB_FIXED_PRIO_EN
   // Lowest set index wins; higher indices may starve.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_vld && req[i]) begin
            win     = PTR_W'(i);
            win_vld = 1'b1;
         end
      end
   end
`else
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W:0]      scan_sum;
   logic [PTR_W-1:0]    scan_idx;

   // Scan from rr_ptr upward, wrapping modulo N_REQ; the first set bit wins.
   // The extra bit in scan_sum keeps the wrap exact for non-power-of-2 N_REQ.
   always_comb begin
      win      = '0;
      win_vld  = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         scan_idx = (scan_sum >= (PTR_W+1)'(N_REQ)) ?
                    PTR_W'(scan_sum - (PTR_W+1)'(N_REQ)) : scan_sum[PTR_W-1:0];
         if (!win_vld && req[scan_idx]) begin
            win     = scan_idx;
            win_vld = 1'b1;
         end
      end
   end
`endif

   // Control FSM: grant and ack come straight from flops, so there is no
   // combinational path from req to any output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         ack      <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
         rr_ptr   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  grant    <= ONE << win;
                  lat_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                  lat_data <= req_data[int'(win)*DATA_W +: DATA_W];
`ifndef REG_ARB_FIXED_PRIO_EN
                  rr_ptr   <= (win == PTR_W'(N_REQ-1)) ? '0 : win + PTR_W'(1);
`endif
                  state    <= GRANT;
               end
            end
            GRANT: begin
               ack   <= 1'b1;
               state <= WRITE;
            end
            WRITE: begin
               // Spending this edge before IDLE lets the requester drop req on
               // ack without being granted a second time.
               ack   <= 1'b0;
               grant <= '0;
               state <= IDLE;
            end
            default: begin
               ack   <= 1'b0;
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

   // Register bank and read port. A read of the entry written on the same edge
   // returns the old contents; the new value shows up one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         rd_data <= bank[rd_addr];
         if (state == GRANT) begin
            bank[lat_addr] <= lat_data;
         end
      end
   end

endmodule
